renode_apb3_requester: RTL and testbench

- APB3 requester (manager) that drives the completer side of the team's APB3 interface bundle.
- Accepts single read/write commands on a valid/ready request channel, runs the APB3 SETUP/ACCESS phases, and waits on pready with an optional timeout.
- Returns read data and error status on a valid/ready response channel.
- Sits between the Renode bus-transaction front end and any RTL APB3 completer under co-simulation.

---
 rtl/renode_apb3_pkg.sv | 22 ++
 rtl/renode_apb3_requester_if.sv | 43 ++++
 rtl/renode_apb3_timeout.sv | 37 +++
 rtl/renode_apb3_requester.sv | 118 +++++++++++
 tb/tb_renode_apb3_requester.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/renode_apb3_pkg.sv
// Shared types for the Renode APB3 requester: FSM states, bus typedefs and
// the DataWidth legality check used at elaboration.
package renode_apb3_pkg;

  localparam int DefAddressWidth = 20;
  localparam int DefDataWidth    = 32;

  typedef logic [DefAddressWidth-1:0] address_t;
  typedef logic [DefDataWidth-1:0]    data_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    RESPOND = 2'd3
  } state_e;

  function automatic bit data_width_legal(input int width);
    return (width == 8) || (width == 16) || (width == 24) || (width == 32);
  endfunction

endpackage

// File: rtl/renode_apb3_requester_if.sv
// Request/response channel plus APB3 bus; master is the requester's view,
// slave is the view of the Renode front end and the completer combined.
interface renode_apb3_requester_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [AddressWidth-1:0] req_addr;
  logic [DataWidth-1:0]    req_wdata;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DataWidth-1:0]    rsp_rdata;
  logic                    rsp_error;
  logic                    rsp_timeout;

  logic [AddressWidth-1:0] paddr;
  logic                    pselx;
  logic                    penable;
  logic                    pwrite;
  logic [DataWidth-1:0]    pwdata;
  logic                    pready;
  logic [DataWidth-1:0]    prdata;
  logic                    pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  pready, prdata, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    output paddr, pselx, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output pready, prdata, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
    input  paddr, pselx, penable, pwrite, pwdata
  );

endinterface

// File: rtl/renode_apb3_timeout.sv
// Wait-state counter: counts enabled cycles, flags expiry at Limit-1.
// Limit == 0 never expires; clear has priority over enable.
module renode_apb3_timeout #(
  parameter int Limit = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CntW = (Limit > 1) ? $clog2(Limit) : 1;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;

  assign expired_o = (Limit != 0) && (cnt_q == CntW'(Limit - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/renode_apb3_requester.sv
// APB3 manager for Renode co-simulation: one command in flight, 3 cycles from
// acceptance to response plus one per wait state; response held until rsp_ready.
module renode_apb3_requester
  import renode_apb3_pkg::*;
#(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 256
) (
  input  logic                      pclk,
  input  logic                      preset,
  renode_apb3_requester_if.master   bus
);

  if (!data_width_legal(DataWidth)) begin : g_dw_check
    $error("renode_apb3_requester: DataWidth %0d must be 8, 16, 24 or 32", DataWidth);
  end

  state_e                  state_q;
  logic [AddressWidth-1:0] paddr_q;
  logic [DataWidth-1:0]    pwdata_q;
  logic                    pselx_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic                    rsp_valid_q;
  logic [DataWidth-1:0]    rsp_rdata_q;
  logic                    rsp_error_q;
  logic                    rsp_timeout_q;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_expired;

  assign cnt_en  = (state_q == ACCESS) && !bus.pready;
  assign cnt_clr = (state_q == RESPOND) && bus.rsp_ready;

  renode_apb3_timeout #(
    .Limit (TimeoutCycles)
  ) u_timeout (
    .clk_i     (pclk),
    .rst_i     (preset),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pselx_q       <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_error_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            paddr_q  <= bus.req_addr;
            pwrite_q <= bus.req_write;
            // Reads leave pwdata alone so the bus stays quiet.
            if (bus.req_write) begin
              pwdata_q <= bus.req_wdata;
            end
            pselx_q  <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            pselx_q       <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
            rsp_error_q   <= bus.pslverr;
            rsp_timeout_q <= 1'b0;
            state_q       <= RESPOND;
          end else if (cnt_expired) begin
            pselx_q       <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            state_q       <= RESPOND;
          end
        end
        RESPOND: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_error   = rsp_error_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.paddr       = paddr_q;
  assign bus.pselx       = pselx_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.pwdata      = pwdata_q;

endmodule

// File: tb/tb_renode_apb3_requester.sv
// Directed bench for renode_apb3_requester with a small APB3 completer model
// whose wait states, error and hang behaviour are set per scenario.
module tb_renode_apb3_requester;

  logic pclk;
  logic preset;

  int checks   = 0;
  int failures = 0;

  int          ws;
  bit          hang;
  bit          err;
  logic [31:0] rd_val;
  int          acc_cnt;

  renode_apb3_requester_if #(.AddressWidth(20), .DataWidth(32)) bus ();

  renode_apb3_requester #(
    .AddressWidth  (20),
    .DataWidth     (32),
    .TimeoutCycles (4)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Completer: ready after ws ACCESS cycles unless hung; junk on prdata otherwise.
  always @(posedge pclk) begin
    if (bus.pselx && bus.penable) acc_cnt <= acc_cnt + 1;
    else                          acc_cnt <= 0;
  end
  assign bus.pready  = bus.pselx && bus.penable && !hang && (acc_cnt >= ws);
  assign bus.prdata  = bus.pready ? rd_val : 32'hA5A5_A5A5;
  assign bus.pslverr = bus.pready && err;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [19:0] addr, input logic [31:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  task automatic test_reset;
    preset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if ({bus.pselx, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {bus.pselx, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout});
    end
    checks++;
    if (bus.paddr !== 20'h0 || bus.pwdata !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rsp_rdata=%h required all 0",
               bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_req_ready: got %b required 1", bus.req_ready);
    end
    preset = 1'b0;
    tick();
  endtask

  task automatic test_write;
    ws = 0; hang = 0; err = 0; bus.rsp_ready = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL wr_req_ready: got %b required 1", bus.req_ready);
    end
    drive_req(1'b1, 20'h00010, 32'hDEAD_BEEF);
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.pselx, bus.penable, bus.rsp_valid} !== 3'b100) begin
      failures++; $display("FAIL wr_setup: sel/en/rsp got %b required 100", {bus.pselx, bus.penable, bus.rsp_valid});
    end
    tick();
    checks++;
    if ({bus.pselx, bus.penable, bus.pwrite} !== 3'b111 || bus.paddr !== 20'h00010 || bus.pwdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_access: sel/en/wr=%b paddr=%h pwdata=%h required 111 00010 deadbeef",
               {bus.pselx, bus.penable, bus.pwrite}, bus.paddr, bus.pwdata);
    end
    tick();
    checks++;
    if ({bus.pselx, bus.penable, bus.rsp_valid, bus.rsp_error} !== 4'b0010 || bus.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL wr_rsp: sel/en/vld/err=%b rdata=%h required 0010 00000000",
               {bus.pselx, bus.penable, bus.rsp_valid, bus.rsp_error}, bus.rsp_rdata);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      failures++; $display("FAIL wr_idle: vld/req_ready got %b required 01", {bus.rsp_valid, bus.req_ready});
    end
  endtask

  task automatic test_read_wait;
    ws = 3; rd_val = 32'h1234_5678;
    drive_req(1'b0, 20'h00020, 32'hCAFE_F00D);
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.req_valid = 1'b0;
      checks++;
      if (bus.paddr !== 20'h00020 || bus.pwdata !== 32'hDEAD_BEEF || bus.rsp_valid !== (c == 6)) begin
        failures++;
        $display("FAIL rd_wait_c%0d: paddr=%h pwdata=%h vld=%b required 00020 deadbeef %b",
                 c, bus.paddr, bus.pwdata, bus.rsp_valid, (c == 6));
      end
    end
    checks++;
    if (bus.rsp_rdata !== 32'h1234_5678 || {bus.rsp_error, bus.rsp_timeout} !== 2'b00) begin
      failures++;
      $display("FAIL rd_wait_rsp: rdata=%h err/to=%b required 12345678 00",
               bus.rsp_rdata, {bus.rsp_error, bus.rsp_timeout});
    end
    tick();
  endtask

  task automatic test_slverr;
    ws = 1; err = 1; rd_val = 32'h0000_0BAD;
    drive_req(1'b0, 20'h00030, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.pselx, bus.penable} !== 5'b11000
        || bus.rsp_rdata !== 32'h0000_0BAD) begin
      failures++;
      $display("FAIL slverr: vld/err/to/sel/en=%b rdata=%h required 11000 00000bad",
               {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.pselx, bus.penable}, bus.rsp_rdata);
    end
    tick();
    err = 0;
  endtask

  task automatic test_timeout;
    hang = 1; ws = 0;
    drive_req(1'b0, 20'h00040, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if ({bus.pselx, bus.penable, bus.rsp_valid} !== 3'b110) begin
      failures++; $display("FAIL to_access4: sel/en/vld got %b required 110", {bus.pselx, bus.penable, bus.rsp_valid});
    end
    tick();
    checks++;
    if ({bus.pselx, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 4'b0111 || bus.rsp_rdata !== 32'h0) begin
      failures++;
      $display("FAIL to_abort: sel/vld/err/to=%b rdata=%h required 0111 00000000",
               {bus.pselx, bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}, bus.rsp_rdata);
    end
    tick();
    hang = 0; ws = 3; rd_val = 32'h89AB_CDEF;
    drive_req(1'b0, 20'h00044, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL to_late_early: vld got %b required 0", bus.rsp_valid);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_error, bus.rsp_timeout} !== 3'b100 || bus.rsp_rdata !== 32'h89AB_CDEF) begin
      failures++;
      $display("FAIL to_late_ready: vld/err/to=%b rdata=%h required 100 89abcdef",
               {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout}, bus.rsp_rdata);
    end
    tick();
  endtask

  task automatic test_backpressure;
    ws = 0; bus.rsp_ready = 1'b0;
    drive_req(1'b1, 20'h00050, 32'h1111_1111);
    tick();
    drive_req(1'b1, 20'h00060, 32'h2222_2222);
    repeat (2) tick();
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_error, bus.rsp_timeout} !== 4'b1000
          || bus.rsp_rdata !== 32'h0 || bus.paddr !== 20'h00050) begin
        failures++;
        $display("FAIL bp_hold_%0d: vld/rdy/err/to=%b rdata=%h paddr=%h required 1000 00000000 00050",
                 i, {bus.rsp_valid, bus.req_ready, bus.rsp_error, bus.rsp_timeout}, bus.rsp_rdata, bus.paddr);
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      failures++; $display("FAIL bp_release: rdy/vld got %b required 10", {bus.req_ready, bus.rsp_valid});
    end
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if (bus.pselx !== 1'b1 || bus.paddr !== 20'h00060 || bus.pwdata !== 32'h2222_2222) begin
      failures++;
      $display("FAIL bp_second: sel=%b paddr=%h pwdata=%h required 1 00060 22222222",
               bus.pselx, bus.paddr, bus.pwdata);
    end
    repeat (3) tick();
  endtask

  task automatic test_back_to_back;
    ws = 0; bus.rsp_ready = 1'b1;
    drive_req(1'b1, 20'h00070, 32'hAAAA_AAAA);
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 1) drive_req(1'b1, 20'h00074, 32'hBBBB_BBBB);
      checks++;
      if (bus.req_ready !== (c == 4)) begin
        failures++; $display("FAIL b2b_rdy_c%0d: got %b required %b", c, bus.req_ready, (c == 4));
      end
    end
    tick();
    bus.req_valid = 1'b0;
    checks++;
    if ({bus.pselx, bus.penable} !== 2'b10 || bus.paddr !== 20'h00074) begin
      failures++;
      $display("FAIL b2b_second: sel/en=%b paddr=%h required 10 00074", {bus.pselx, bus.penable}, bus.paddr);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid;
    hang = 1;
    drive_req(1'b0, 20'h0007C, 32'h0);
    tick();
    bus.req_valid = 1'b0;
    tick();
    checks++;
    if ({bus.pselx, bus.penable} !== 2'b11) begin
      failures++; $display("FAIL rm_access: sel/en got %b required 11", {bus.pselx, bus.penable});
    end
    preset = 1'b1;
    tick();
    checks++;
    if ({bus.pselx, bus.penable, bus.rsp_valid, bus.req_ready} !== 4'b0001 || bus.paddr !== 20'h0) begin
      failures++;
      $display("FAIL rm_reset: sel/en/vld/rdy=%b paddr=%h required 0001 00000",
               {bus.pselx, bus.penable, bus.rsp_valid, bus.req_ready}, bus.paddr);
    end
    preset = 1'b0; hang = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.pselx !== 1'b0) begin
        failures++; $display("FAIL rm_no_rsp_%0d: vld=%b sel=%b required 0 0", i, bus.rsp_valid, bus.pselx);
      end
    end
  endtask

  initial begin
    ws = 0; hang = 0; err = 0; rd_val = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
